// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiplier and restoring divider on one datapath.
// Define MULDIV_FAST_MUL_EN to compute multiplies combinationally in a single cycle.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  logic [2:0]      func,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result
);

   // state  | meaning
   // IDLE   | waiting for an op, in_ready high
   // CALC   | XLEN iterations of shift-add or restoring divide
   // FIX    | sign correction and result select
   // DONE   | result held until out_ready
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [XLEN-1:0]  acc_hi, acc_lo, opb;
   logic [2:0]       fn;
   logic             neg_main, neg_rem;

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);

   logic            sa_en, sb_en, sign_a, sign_b, div_zero, div_ovf;
   logic [XLEN-1:0] mag_a, mag_b, special_res;

   assign sa_en    = func[2] ? ~func[0] : (func[1:0] != 2'b11);
   assign sb_en    = func[2] ? ~func[0] : ~func[1];
   assign sign_a   = sa_en & operand_a[XLEN-1];
   assign sign_b   = sb_en & operand_b[XLEN-1];
   assign mag_a    = sign_a ? -operand_a : operand_a;
   assign mag_b    = sign_b ? -operand_b : operand_b;
   assign div_zero = func[2] && (operand_b == '0);
   assign div_ovf  = func[2] && !func[0] && (operand_a == MOST_NEG) && (operand_b == '1);

   always_comb begin
      special_res = '0;
      if (div_zero)
         special_res = func[1] ? operand_a : '1;
      else if (div_ovf)
         special_res = func[1] ? '0 : operand_a;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
   logic [XLEN-1:0]   fast_res;
   assign fast_a    = {{XLEN{sa_en & operand_a[XLEN-1]}}, operand_a};
   assign fast_b    = {{XLEN{sb_en & operand_b[XLEN-1]}}, operand_b};
   assign fast_prod = fast_a * fast_b;
   assign fast_res  = (func[1:0] == 2'b00) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

   // Multiply: {acc_hi,acc_lo} is the product with the multiplier shifting out of acc_lo.
   // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out and quotient in.
   logic [XLEN:0]   mul_sum, div_sh;
   logic [XLEN-1:0] div_diff;
   logic            div_ge;

   assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
   assign div_sh   = {acc_hi, acc_lo[XLEN-1]};
   assign div_ge   = (div_sh >= {1'b0, opb});
   assign div_diff = div_sh[XLEN-1:0] - opb;

   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

   assign prod_fix = neg_main ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
   assign quo_fix  = neg_main ? -acc_lo : acc_lo;
   assign rem_fix  = neg_rem  ? -acc_hi : acc_hi;

   always_comb begin
      fix_res = '0;
      if (fn[2])
         fix_res = fn[1] ? rem_fix : quo_fix;
      else if (fn[1:0] == 2'b00)
         fix_res = prod_fix[XLEN-1:0];
      else
         fix_res = prod_fix[2*XLEN-1:XLEN];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opb      <= '0;
         fn       <= '0;
         neg_main <= 1'b0;
         neg_rem  <= 1'b0;
         result   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  fn       <= func;
                  neg_main <= sign_a ^ sign_b;
                  neg_rem  <= sign_a;
                  if (div_zero || div_ovf) begin
                     result <= special_res;
                     state  <= S_DONE;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (!func[2]) begin
                     result <= fast_res;
                     state  <= S_DONE;
                  end
`endif
                  else begin
                     acc_hi <= '0;
                     acc_lo <= mag_a;
                     opb    <= mag_b;
                     cnt    <= CNT_W'(XLEN);
                     state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (fn[2]) begin
                  acc_hi <= div_ge ? div_diff : div_sh[XLEN-1:0];
                  acc_lo <= {acc_lo[XLEN-2:0], div_ge};
               end else begin
                  acc_hi <= mul_sum[XLEN:1];
                  acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
               end
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1))
                  state <= S_FIX;
            end
            S_FIX: begin
               result <= fix_res;
               state  <= S_DONE;
            end
            default: begin
               if (out_ready)
                  state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit (XLEN=32): results, latency, back-pressure and async reset.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic [2:0]  func = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] result;

   int n_pass  = 0;
   int n_total = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .func      (func),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f;
      logic [31:0] exp;
      bit          special;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
   endtask

   function automatic int exp_lat(input logic [2:0] f, input bit special);
      if (special) return 1;
      if (FAST && !f[2]) return 1;
      return 34;
   endfunction

   task automatic start_op(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f);
      int w;
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
      operand_a = a;
      operand_b = b;
      func      = f;
      in_valid  = 1'b1;
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      operand_b = $urandom;
      func      = 3'($urandom);
   endtask

   // Returns the cycle (accept edge = 0) in which out_valid is first seen high.
   task automatic wait_done(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 200) begin
         operand_a = $urandom;
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f, input logic [31:0] exp, input int lat);
      int cyc;
      start_op(name, a, b, f);
      wait_done(cyc);
      check({name, " latency"}, cyc, lat);
      check({name, " result"}, result, exp);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({name, " out_valid drop"}, {31'b0, out_valid}, 32'd0);
   endtask

   initial begin
      int          cyc;
      logic [31:0] held;
      bit          stable;

      vecs[0]  = '{"mul_7_m3",        32'h00000007, 32'hFFFFFFFD, 3'd0, 32'hFFFFFFEB, 1'b0};
      vecs[1]  = '{"mulh_m1_m1",      32'hFFFFFFFF, 32'hFFFFFFFF, 3'd1, 32'h00000000, 1'b0};
      vecs[2]  = '{"mulhsu_m1_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'hFFFFFFFF, 1'b0};
      vecs[3]  = '{"mulhu_max_max",   32'hFFFFFFFF, 32'hFFFFFFFF, 3'd3, 32'hFFFFFFFE, 1'b0};
      vecs[4]  = '{"div_m7_2",        32'hFFFFFFF9, 32'h00000002, 3'd4, 32'hFFFFFFFD, 1'b0};
      vecs[5]  = '{"rem_m7_2",        32'hFFFFFFF9, 32'h00000002, 3'd6, 32'hFFFFFFFF, 1'b0};
      vecs[6]  = '{"divu_min_3",      32'h80000000, 32'h00000003, 3'd5, 32'h2AAAAAAA, 1'b0};
      vecs[7]  = '{"remu_min_3",      32'h80000000, 32'h00000003, 3'd7, 32'h00000002, 1'b0};
      vecs[8]  = '{"div_by_zero",     32'h12345678, 32'h00000000, 3'd4, 32'hFFFFFFFF, 1'b1};
      vecs[9]  = '{"remu_by_zero",    32'h12345678, 32'h00000000, 3'd7, 32'h12345678, 1'b1};
      vecs[10] = '{"div_overflow",    32'h80000000, 32'hFFFFFFFF, 3'd4, 32'h80000000, 1'b1};
      vecs[11] = '{"rem_overflow",    32'h80000000, 32'hFFFFFFFF, 3'd6, 32'h00000000, 1'b1};
      vecs[12] = '{"mul_shift16",     32'h12345678, 32'h00000010, 3'd0, 32'h23456780, 1'b0};
      vecs[13] = '{"divu_100_7",      32'h00000064, 32'h00000007, 3'd5, 32'h0000000E, 1'b0};
      vecs[14] = '{"rem_7_m2",        32'h00000007, 32'hFFFFFFFE, 3'd6, 32'h00000001, 1'b0};
      vecs[15] = '{"div_7_m2",        32'h00000007, 32'hFFFFFFFE, 3'd4, 32'hFFFFFFFD, 1'b0};
      vecs[16] = '{"mulhu_min_2",     32'h80000000, 32'h00000002, 3'd3, 32'h00000001, 1'b0};
      vecs[17] = '{"divu_by_zero",    32'h00000055, 32'h00000000, 3'd5, 32'hFFFFFFFF, 1'b1};
      vecs[18] = '{"rem_by_zero",     32'hFFFFFF00, 32'h00000000, 3'd6, 32'hFFFFFF00, 1'b1};
      vecs[19] = '{"mulh_min_min",    32'h80000000, 32'h80000000, 3'd1, 32'h40000000, 1'b0};

      #1;
      check("reset in_ready", {31'b0, in_ready}, 32'd1);
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      check("reset result", result, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 20; i++)
         run_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].f, vecs[i].exp,
                exp_lat(vecs[i].f, vecs[i].special));

      // Back-pressure: hold the result in DONE while offering a competing op.
      start_op("bp", 32'h00000064, 32'h00000007, 3'd5);
      wait_done(cyc);
      check("bp latency", cyc, 34);
      held   = result;
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         operand_a = 32'hDEADBEEF;
         operand_b = 32'h1;
         func      = 3'd0;
         in_valid  = 1'b1;
         @(posedge clk);
         #1;
         if (!out_valid || in_ready || result !== held) stable = 1'b0;
      end
      in_valid = 1'b0;
      check("bp stable", {31'b0, stable}, 32'd1);
      check("bp result", result, 32'h0000000E);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp idle in_ready", {31'b0, in_ready}, 32'd1);
      check("bp idle out_valid", {31'b0, out_valid}, 32'd0);

      // Async reset in the middle of CALC, then a clean op afterwards.
      start_op("rst_mid", 32'h00000064, 32'h00000007, 3'd5);
      repeat (14) @(posedge clk);
      #2;
      check("rst_mid busy", {31'b0, in_ready}, 32'd0);
      rst = 1'b1;
      #1;
      check("rst_mid in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_mid out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_mid result", result, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      run_op("after_rst", 32'hFFFFFFF9, 32'h00000002, 3'd4, 32'hFFFFFFFD, 34);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
